sram_port_ctrl: RTL
===================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 11, SRAM word address width.
REQ-002 SHALL have parameters: DATA_WIDTH, default 32, word width; NUM_WMASKS, default 4, byte-lane count (DATA_WIDTH/8).
REQ-003 SHALL have parameters: TAG_WIDTH, default 4, read tag width; RESP_DEPTH, default 2, response FIFO entries (min 2).
REQ-004 SHALL have ports:
clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have req_valid in 1 / req_ready out 1, the request handshake.
REQ-007 SHALL have the request fields: req_we in 1 (1=write); req_wmask in NUM_WMASKS; req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH; req_tag in TAG_WIDTH.
REQ-008 SHALL have resp_valid out 1 / resp_ready in 1, the read response handshake.
REQ-009 SHALL have the response fields: resp_data out DATA_WIDTH; resp_tag out TAG_WIDTH.
REQ-010 SHALL have the SRAM RW-port drive, all registered: sram_csb0 out 1 (active-low select); sram_web0 out 1 (active-low write); sram_wmask0 out NUM_WMASKS; sram_addr0 out ADDR_WIDTH; sram_din0 out DATA_WIDTH.
REQ-011 SHALL have sram_dout0 in DATA_WIDTH, the macro read data.
REQ-012 SHALL have busy out 1, high while any read is outstanding (in flight or queued).

Function
REQ-013 SHALL treat a request as accepted on a posedge where req_valid && req_ready.
REQ-014 SHALL, on accepting request at posedge N, drive it on sram_* for cycle N+1: csb0=0, web0=!req_we, addr0, din0 and wmask0 copied.
REQ-015 SHALL otherwise hold sram_csb0=1 for cycle N+1, with sram_addr0/din0/wmask0/web0 holding their previous values.
REQ-016 SHALL treat an accepted write with req_wmask==0 as a no-op: csb0 stays 1, nothing issued.
REQ-017 SHALL sample sram_dout0 at posedge N+2 for a read issued in cycle N+1, and push it with the matching tag into the response FIFO.
REQ-018 SHALL give fixed read latency: resp_valid is asserted in cycle N+2 when the FIFO is empty and resp_ready was high.
REQ-019 SHALL keep outstanding = (read in issue stage) + FIFO occupancy, with writes never counted.
REQ-020 SHALL drive req_ready = !rst && (outstanding - pop < RESP_DEPTH), where pop = resp_valid && resp_ready; this is combinational and allows a read accept in the same cycle as a pop.
REQ-021 SHALL accept writes under the same req_ready; no write response is generated.
REQ-022 SHALL sustain one request per cycle with resp_ready held high and RESP_DEPTH>=2.
REQ-023 SHALL return responses in request order, the FIFO being first-in first-out with pointer wrap at RESP_DEPTH.
REQ-024 SHALL keep resp_data/resp_tag stable while resp_valid && !resp_ready.
REQ-025 SHALL handle simultaneous FIFO push and pop: occupancy unchanged; push into an empty FIFO with pop not possible that cycle.
REQ-026 SHALL never overflow the FIFO; an attempted push when full is a design error, flagged by a simulation assertion.
REQ-027 SHALL assert busy = (outstanding != 0).
REQ-028 SHALL make a read issued in the cycle after a write to the same address return the new data, since the macro writes on negedge before the next capture, with no extra hazard logic.

Reset
REQ-029 SHALL, with rst high at a posedge, set sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
REQ-030 SHALL, on the same reset, empty the FIFO and clear the issue stage, giving resp_valid=0, resp_data=0, resp_tag=0, busy=0.
REQ-031 SHALL hold req_ready=0 while rst is high.
REQ-032 SHALL discard an in-flight read when reset arrives mid-operation; no response appears after reset deasserts.
REQ-033 SHALL accept requests from the first posedge after rst deasserts.

Verification
REQ-034 Write addr 0x005 data 0xDEADBEEF mask 0xF, then read addr 0x005 tag 3 the next cycle -> resp_valid 2 cycles after read accept, resp_data 0xDEADBEEF, resp_tag 3.
REQ-035 Byte write mask 0x2 data 0x0000AB00 over word 0x11223344, then read -> 0x1122AB44; mask 0x0 write -> csb0 never low.
REQ-036 Back-to-back reads, tags 0..7, resp_ready=1 -> req_ready constantly 1, eight responses in consecutive cycles, in order.
REQ-037 resp_ready=0 with reads issued -> req_ready drops after RESP_DEPTH reads; raising resp_ready drains in order with no loss or duplicate.
REQ-038 rst pulse one cycle after a read accept -> no response after reset, busy=0, sram_csb0=1, next read returns correct data.
REQ-039 Read of max address 0x7FF followed by address 0x000 -> both correct, no address wrap artefacts.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: request/response front end for a single-port RW SRAM macro.
// Requests are registered onto the macro pins. Read data is captured one clock
// later into a small response FIFO, tagged with the request tag. Reads are
// admitted only while the FIFO is guaranteed to have room for them.
module sram_port_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    // Wide enough for FIFO occupancy plus the one read in the issue stage.
    localparam int CW = $clog2(RESP_DEPTH + 2);

    logic                  csb_q, web_q;
    logic [NUM_WMASKS-1:0] wmask_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    logic                  rd_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    logic [DATA_WIDTH-1:0] data_mem_q [RESP_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem_q  [RESP_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         cnt_q;

    logic          accept, issue, pop, push;
    logic [CW-1:0] outstanding;

    // Handshake, issue qualification and FIFO output view.
    always_comb begin
        resp_valid  = (cnt_q != '0);
        pop         = resp_valid && resp_ready;
        push        = rd_q;
        outstanding = cnt_q + CW'(rd_q);
        // Counting the pop lets a read enter in the same cycle a slot frees up.
        req_ready   = !rst && ((outstanding - CW'(pop)) < CW'(RESP_DEPTH));
        accept      = req_valid && req_ready;
        // An all-zero-mask write has nothing to do, so the macro stays deselected.
        issue       = accept && (!req_we || (req_wmask != '0));
        busy        = (outstanding != '0);
        resp_data   = resp_valid ? data_mem_q[rptr_q] : '0;
        resp_tag    = resp_valid ? tag_mem_q[rptr_q]  : '0;
    end

    // Macro pin registers, issue stage and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            tag_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            csb_q <= !issue;
            if (issue) begin
                web_q   <= !req_we;
                wmask_q <= req_wmask;
                addr_q  <= req_addr;
                din_q   <= req_wdata;
            end
            rd_q <= accept && !req_we;
            if (accept && !req_we) tag_q <= req_tag;
            if (push) wptr_q <= (wptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_q <= (rptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            // Admission control should make a push into a full FIFO impossible.
            assert (!(push && !pop && (cnt_q == CW'(RESP_DEPTH))));
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem_q[wptr_q] <= sram_dout0;
            tag_mem_q[wptr_q]  <= tag_q;
        end
    end

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule
